spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_master.sv | 105 ++++++++++
 tb/tb_spi_master.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/clock
// parameters, common to spi_master and spi_slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_t;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's request/response handshake and serial lines.
//   master modport : view of spi_master (drives busy/done/rx_data/ss_n/sck/mosi)
//   slave modport  : view of the client and serial peer (drives start/tx_data/miso)
interface spi_master_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              ss_n;
  logic              sck;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, ss_n, sck, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, ss_n, sck, mosi
  );
endinterface

// File: rtl/spi_clk_div.sv
// SCK half-period timer.
//   clk, rst : system clock, synchronous active-high reset
//   enable   : counts while high, held at zero while low
//   tick     : one-cycle pulse every CLK_DIV enabled cycles
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero while disabled so the first tick after enable lands
  // exactly CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, one DATA_W-bit frame per accepted start.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : start/tx_data request, busy/done/rx_data response,
//              ss_n/sck/mosi/miso serial lines
//
// state | meaning
// IDLE  | ss_n high, waiting for start
// SETUP | ss_n low, first mosi bit settling, sck low for one half-period
// XFER  | DATA_W sck periods (high half then low half)
// HOLD  | sck low, ss_n still low for one half-period
// DONE  | single cycle: ss_n high, done pulse, rx_data updated; accepts start
module spi_master import spi_pkg::*; #(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BITS      = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] LAST_FALL = BIT_W'(DATA_W - 1);

  spi_state_t        state, state_nxt;
  logic              active, accept, tick;
  logic              rise, fall, xfer_end;
  logic              sck_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_q;

  assign active = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign accept = bus.start && !active;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .enable (active),
    .tick   (tick)
  );

  // bit_cnt counts completed sck falls; once it reaches DATA_W the next
  // tick closes the final low half instead of starting another period.
  assign rise     = tick && !sck_q &&
                    ((state == SETUP) || ((state == XFER) && (bit_cnt != BITS)));
  assign fall     = tick && sck_q && (state == XFER);
  assign xfer_end = tick && !sck_q && (state == XFER) && (bit_cnt == BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = accept ? SETUP : IDLE;
      SETUP:      if (tick)     state_nxt = XFER;
      XFER:       if (xfer_end) state_nxt = HOLD;
      HOLD:       if (tick)     state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q   <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
    end else begin
      if (accept) begin
        tx_sr   <= bus.tx_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
        sck_q   <= 1'b0;
      end
      if (rise) begin
        sck_q <= 1'b1;
        rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
      end
      if (fall) begin
        sck_q   <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        // The last bit stays on mosi through HOLD.
        if (bit_cnt != LAST_FALL) begin
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
      if ((state == HOLD) && tick) begin
        rx_q <= rx_sr;
      end
    end
  end

  assign bus.busy    = active;
  assign bus.done    = (state == DONE);
  assign bus.ss_n    = !active;
  assign bus.sck     = sck_q;
  assign bus.mosi    = active ? tx_sr[DATA_W-1] : 1'b0;
  assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: dut0 uses CLK_DIV=4, dut1 uses CLK_DIV=1.
module tb_spi_master;
  localparam int LAT0 = 1 + (2 * 8 + 2) * 4;
  localparam int LAT1 = 1 + (2 * 8 + 2) * 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start_r;
  logic [7:0] tx_r [2];
  logic [1:0] mmode [2];  // 0: miso=0, 1: miso=1, 2: loopback

  spi_master_if #(.DATA_W(8)) bus0 ();
  spi_master_if #(.DATA_W(8)) bus1 ();

  spi_master #(.CLK_DIV(4), .DATA_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start   = start_r[0];
  assign bus0.tx_data = tx_r[0];
  assign bus0.miso    = (mmode[0] == 2'd2) ? bus0.mosi : mmode[0][0];
  assign bus1.start   = start_r[1];
  assign bus1.tx_data = tx_r[1];
  assign bus1.miso    = (mmode[1] == 2'd2) ? bus1.mosi : mmode[1][0];

  logic [1:0] sck_w, mosi_w, ss_w, busy_w, done_w;
  logic [7:0] rx_w [2];
  assign sck_w[0]  = bus0.sck;   assign sck_w[1]  = bus1.sck;
  assign mosi_w[0] = bus0.mosi;  assign mosi_w[1] = bus1.mosi;
  assign ss_w[0]   = bus0.ss_n;  assign ss_w[1]   = bus1.ss_n;
  assign busy_w[0] = bus0.busy;  assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus0.done;  assign done_w[1] = bus1.done;
  assign rx_w[0]   = bus0.rx_data;
  assign rx_w[1]   = bus1.rx_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int viol = 0;
  int rises [2];
  logic [7:0] bits [2];
  logic [1:0] sck_prev;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts sck rises, captures mosi at each rise, checks sck/ss_n
  // relationship, and scores every done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (sck_w[d] && !sck_prev[d]) begin
        rises[d]++;
        bits[d] = {bits[d][6:0], mosi_w[d]};
      end
      if (sck_w[d] && ss_w[d]) viol++;
      if (done_w[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_done dut%0d: got done=1 expected no frame (cycle %0d)", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("rx_data dut%0d", d), 32'(rx_w[d]), 32'(e.rx));
          chk($sformatf("done_cycle dut%0d", d), 32'(cyc), 32'(e.cyc));
          chk($sformatf("sck_rises dut%0d", d), 32'(rises[d]), 32'd8);
          chk($sformatf("mosi_bits dut%0d", d), 32'(bits[d]), 32'(e.tx));
          chk($sformatf("done_busy_ss dut%0d", d), 32'({busy_w[d], ss_w[d]}), 32'b01);
        end
      end
      if (ss_w[d]) begin
        rises[d] = 0;
        bits[d]  = 8'h00;
      end
      sck_prev[d] = sck_w[d];
    end
  end

  // Drive a one-cycle start at the current cycle (cycle 0) and queue the
  // expected result; returns in cycle 1.
  task automatic issue(input int d, input logic [7:0] tx, input logic [7:0] rx);
    exp_t e;
    e.rx  = rx;
    e.tx  = tx;
    e.cyc = cyc + ((d == 0) ? LAT0 : LAT1);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    start_r[d] = 1'b1;
    tx_r[d]    = tx;
    @(negedge clk);
    start_r[d] = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    start_r = 2'b00;
    tx_r[0] = 8'h00;  tx_r[1] = 8'h00;
    mmode[0] = 2'd2;  mmode[1] = 2'd2;
    rises[0] = 0;     rises[1] = 0;
    bits[0] = 8'h00;  bits[1] = 8'h00;
    sck_prev = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_state dut0", 32'({bus0.ss_n, bus0.sck, bus0.mosi, bus0.busy, bus0.done, bus0.rx_data}),
        32'({1'b1, 4'b0000, 8'h00}));
    chk("reset_state dut1", 32'({bus1.ss_n, bus1.sck, bus1.mosi, bus1.busy, bus1.done, bus1.rx_data}),
        32'({1'b1, 4'b0000, 8'h00}));
    rst = 1'b0;
    @(negedge clk);

    // Loopback 0xA5
    issue(0, 8'hA5, 8'hA5);
    repeat (80) @(negedge clk);

    // Second start mid-frame with new tx_data is ignored
    issue(0, 8'hA5, 8'hA5);
    repeat (19) @(negedge clk);
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h11;
    @(negedge clk);
    start_r[0] = 1'b0;
    chk("busy_after_ignored_start", 32'(bus0.busy), 32'd1);
    repeat (70) @(negedge clk);

    // miso tied high, then low
    mmode[0] = 2'd1;
    issue(0, 8'h3C, 8'hFF);
    repeat (80) @(negedge clk);
    mmode[0] = 2'd0;
    issue(0, 8'h3C, 8'h00);
    repeat (80) @(negedge clk);
    mmode[0] = 2'd2;

    // Back-to-back with start held high
    e.rx = 8'h5A; e.tx = 8'h5A; e.cyc = cyc + LAT0;     q0.push_back(e);
    e.rx = 8'hC3; e.tx = 8'hC3; e.cyc = cyc + 2 * LAT0; q0.push_back(e);
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h5A;
    @(negedge clk);
    tx_r[0] = 8'hC3;
    repeat (LAT0 - 1) @(negedge clk);
    chk("b2b_gap_ss_high", 32'({bus0.done, bus0.ss_n}), 32'b11);
    @(negedge clk);
    chk("b2b_restart", 32'({bus0.ss_n, bus0.busy}), 32'b01);
    start_r[0] = 1'b0;
    repeat (80) @(negedge clk);

    // CLK_DIV=1 loopback
    issue(1, 8'h80, 8'h80);
    repeat (25) @(negedge clk);

    // Abort at cycle 30, with start coincident with reset
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h77;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (29) @(negedge clk);
    rst        = 1'b1;
    start_r[0] = 1'b1;
    tx_r[0]    = 8'h99;
    @(negedge clk);
    chk("abort_state", 32'({bus0.ss_n, bus0.sck, bus0.busy, bus0.done, bus0.rx_data}),
        32'({1'b1, 3'b000, 8'h00}));
    rst        = 1'b0;
    start_r[0] = 1'b0;
    repeat (100) @(negedge clk);

    chk("sck_high_while_ss_high", 32'(viol), 32'd0);
    chk("pending_frames dut0", 32'(q0.size()), 32'd0);
    chk("pending_frames dut1", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
